// File: rtl/vx_cluster_mem_arb.sv
`default_nettype none
// ============================================================================
// Module  : vx_cluster_mem_arb
// Brief   : Round-robin arbiter sharing one L2 request slot among NUM_REQS
//           socket requesters, with per-requester read credit and tag-based
//           response steering.
// Revision: 1.0 - initial release
// ============================================================================
module vx_cluster_mem_arb #(
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 26,
  parameter int DATA_WIDTH  = 512,
  parameter int TAG_WIDTH   = 8,
  parameter int MAX_PENDING = 8,
  localparam int SEL_BITS   = $clog2(NUM_REQS)
) (
  input  logic                               clk,
  input  logic                               reset,

  input  logic [NUM_REQS-1:0]                req_valid,
  input  logic [NUM_REQS-1:0]                req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]     req_data,
  input  logic [NUM_REQS*DATA_WIDTH/8-1:0]   req_byteen,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]      req_tag,
  output logic [NUM_REQS-1:0]                req_ready,

  output logic                               out_req_valid,
  output logic                               out_req_rw,
  output logic [ADDR_WIDTH-1:0]              out_req_addr,
  output logic [DATA_WIDTH-1:0]              out_req_data,
  output logic [DATA_WIDTH/8-1:0]            out_req_byteen,
  output logic [TAG_WIDTH+SEL_BITS-1:0]      out_req_tag,
  input  logic                               out_req_ready,

  input  logic                               out_rsp_valid,
  input  logic [DATA_WIDTH-1:0]              out_rsp_data,
  input  logic [TAG_WIDTH+SEL_BITS-1:0]      out_rsp_tag,
  output logic                               out_rsp_ready,

  output logic [NUM_REQS-1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]              rsp_data,
  output logic [TAG_WIDTH-1:0]               rsp_tag,
  input  logic [NUM_REQS-1:0]                rsp_ready,

  output logic                               rsp_err,
  output logic                               busy
);

  localparam int c_cnt_w = $clog2(MAX_PENDING + 1);

  logic [SEL_BITS-1:0]     r_ptr;
  logic [c_cnt_w-1:0]      r_pend [NUM_REQS];
  logic                    r_rsp_err;

  logic                    r_out_valid;
  logic                    r_out_rw;
  logic [ADDR_WIDTH-1:0]   r_out_addr;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [DATA_WIDTH/8-1:0] r_out_byteen;
  logic [TAG_WIDTH+SEL_BITS-1:0] r_out_tag;

  logic [NUM_REQS-1:0]     w_eligible;
  logic [NUM_REQS-1:0]     w_grant;
  logic [SEL_BITS-1:0]     w_grant_idx;
  logic                    w_found;
  logic                    w_can_load;
  logic                    w_accept;

  logic [SEL_BITS-1:0]     w_rsp_idx;
  logic                    w_idx_ok;
  logic                    w_rsp_fire;
  logic [NUM_REQS-1:0]     w_pend_nz;
  logic [NUM_REQS-1:0]     w_pend_err;

  // Writes bypass the credit check; reads need a free pending slot.
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_elig
    assign w_eligible[i] = req_valid[i] &&
                           (req_rw[i] || (r_pend[i] < c_cnt_w'(MAX_PENDING)));
  end

  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_found     = 1'b0;
    for (int k = 1; k <= NUM_REQS; k++) begin
      if (!w_found && w_eligible[(int'(r_ptr) + k) % NUM_REQS]) begin
        w_found = 1'b1;
        w_grant[(int'(r_ptr) + k) % NUM_REQS] = 1'b1;
        w_grant_idx = SEL_BITS'((int'(r_ptr) + k) % NUM_REQS);
      end
    end
  end

  assign w_can_load = !r_out_valid || out_req_ready;
  assign w_accept   = w_found && w_can_load;
  assign req_ready  = w_grant & {NUM_REQS{w_can_load}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_ptr       <= SEL_BITS'(NUM_REQS - 1);
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_ptr       <= w_grant_idx;
    end else if (out_req_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Payload is qualified by r_out_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_out_rw     <= req_rw[w_grant_idx];
      r_out_addr   <= req_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      r_out_data   <= req_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
      r_out_byteen <= req_byteen[w_grant_idx*(DATA_WIDTH/8) +: (DATA_WIDTH/8)];
      r_out_tag    <= {req_tag[w_grant_idx*TAG_WIDTH +: TAG_WIDTH], w_grant_idx};
    end
  end

  assign out_req_valid  = r_out_valid;
  assign out_req_rw     = r_out_rw;
  assign out_req_addr   = r_out_addr;
  assign out_req_data   = r_out_data;
  assign out_req_byteen = r_out_byteen;
  assign out_req_tag    = r_out_tag;

  // Indices beyond NUM_REQS are only reachable for non-power-of-2 counts; they are dropped.
  assign w_rsp_idx     = out_rsp_tag[SEL_BITS-1:0];
  assign w_idx_ok      = ({1'b0, w_rsp_idx} < (SEL_BITS+1)'(NUM_REQS));
  assign out_rsp_ready = w_idx_ok ? rsp_ready[w_rsp_idx] : 1'b1;
  assign w_rsp_fire    = out_rsp_valid && out_rsp_ready;
  assign rsp_data      = out_rsp_data;
  assign rsp_tag       = out_rsp_tag[TAG_WIDTH+SEL_BITS-1:SEL_BITS];

  for (genvar j = 0; j < NUM_REQS; j++) begin : g_pend
    logic w_inc;
    logic w_dec;

    assign rsp_valid[j] = out_rsp_valid && w_idx_ok && (w_rsp_idx == SEL_BITS'(j));
    assign w_inc        = w_accept && w_grant[j] && !req_rw[j];
    assign w_dec        = w_rsp_fire && rsp_valid[j];
    assign w_pend_nz[j] = (r_pend[j] != '0);
    assign w_pend_err[j] = w_dec && !w_inc && (r_pend[j] == '0);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_pend[j] <= '0;
      end else if (w_inc && !w_dec) begin
        r_pend[j] <= r_pend[j] + 1'b1;
      end else if (w_dec && !w_inc && (r_pend[j] != '0)) begin
        r_pend[j] <= r_pend[j] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_err <= 1'b0;
    end else if ((|w_pend_err) || (out_rsp_valid && !w_idx_ok)) begin
      r_rsp_err <= 1'b1;
    end
  end

  assign rsp_err = r_rsp_err;
  assign busy    = r_out_valid || (|w_pend_nz);

endmodule
`default_nettype wire

// File: tb/tb_vx_cluster_mem_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_vx_cluster_mem_arb
// Brief   : Directed and random stimulus for vx_cluster_mem_arb, compared
//           every cycle against a transaction-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vx_cluster_mem_arb;

  localparam int NR = 4;
  localparam int AW = 26;
  localparam int DW = 512;
  localparam int TW = 8;
  localparam int MP = 8;
  localparam int SB = 2;

  logic clk = 1'b0;
  logic reset;
  logic [NR-1:0]        req_valid, req_rw, req_ready;
  logic [NR*AW-1:0]     req_addr;
  logic [NR*DW-1:0]     req_data;
  logic [NR*DW/8-1:0]   req_byteen;
  logic [NR*TW-1:0]     req_tag;
  logic                 out_req_valid, out_req_rw, out_req_ready;
  logic [AW-1:0]        out_req_addr;
  logic [DW-1:0]        out_req_data;
  logic [DW/8-1:0]      out_req_byteen;
  logic [TW+SB-1:0]     out_req_tag;
  logic                 out_rsp_valid, out_rsp_ready;
  logic [DW-1:0]        out_rsp_data;
  logic [TW+SB-1:0]     out_rsp_tag;
  logic [NR-1:0]        rsp_valid, rsp_ready;
  logic [DW-1:0]        rsp_data;
  logic [TW-1:0]        rsp_tag;
  logic                 rsp_err, busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit              m_out_valid;
  bit              m_out_rw;
  logic [AW-1:0]   m_out_addr;
  logic [DW-1:0]   m_out_data;
  logic [DW/8-1:0] m_out_byteen;
  logic [TW+SB-1:0] m_out_tag;
  int              m_pend [NR];
  int              m_ptr;
  bit              m_err;

  vx_cluster_mem_arb dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
    .req_data(req_data), .req_byteen(req_byteen), .req_tag(req_tag),
    .req_ready(req_ready),
    .out_req_valid(out_req_valid), .out_req_rw(out_req_rw),
    .out_req_addr(out_req_addr), .out_req_data(out_req_data),
    .out_req_byteen(out_req_byteen), .out_req_tag(out_req_tag),
    .out_req_ready(out_req_ready),
    .out_rsp_valid(out_rsp_valid), .out_rsp_data(out_rsp_data),
    .out_rsp_tag(out_rsp_tag), .out_rsp_ready(out_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out_valid = 1'b0;
    for (int i = 0; i < NR; i++) m_pend[i] = 0;
    m_ptr = NR - 1;
    m_err = 1'b0;
  endtask

  // One clock: randomise payloads, check outputs against the model, advance the model.
  task automatic cycle();
    int gidx;
    int idx;
    bit can_load;
    bit accept;
    bit fire;
    logic [NR-1:0] exp_ready;
    logic [NR-1:0] exp_rsp_valid;
    bit any_pend;
    for (int j = 0; j < NR; j++) begin
      req_addr[j*AW +: AW] = AW'($urandom);
      for (int w = 0; w < DW/32; w++) req_data[j*DW + w*32 +: 32] = $urandom;
      req_byteen[j*(DW/8) +: 32] = $urandom;
      req_byteen[j*(DW/8) + 32 +: 32] = $urandom;
      req_tag[j*TW +: TW] = TW'($urandom);
    end
    for (int w = 0; w < DW/32; w++) out_rsp_data[w*32 +: 32] = $urandom;
    #1;
    if (!reset) model_reset();

    can_load = !m_out_valid || out_req_ready;
    gidx = -1;
    for (int k = 1; k <= NR; k++) begin
      int j;
      j = (m_ptr + k) % NR;
      if (gidx < 0 && req_valid[j] && (req_rw[j] || m_pend[j] < MP)) gidx = j;
    end
    accept = (gidx >= 0) && can_load;
    exp_ready = accept ? (NR'(1) << gidx) : '0;
    idx = int'(out_rsp_tag[SB-1:0]);
    exp_rsp_valid = out_rsp_valid ? (NR'(1) << idx) : '0;
    fire = out_rsp_valid && rsp_ready[idx];
    any_pend = 1'b0;
    for (int i = 0; i < NR; i++) if (m_pend[i] != 0) any_pend = 1'b1;

    chk("req_ready", req_ready, exp_ready);
    chk("out_req_valid", out_req_valid, m_out_valid);
    if (m_out_valid) begin
      chk("out_req_rw", out_req_rw, m_out_rw);
      chk("out_req_addr", out_req_addr, m_out_addr);
      chk("out_req_data", out_req_data, m_out_data);
      chk("out_req_byteen", out_req_byteen, m_out_byteen);
      chk("out_req_tag", out_req_tag, m_out_tag);
    end
    chk("rsp_valid", rsp_valid, exp_rsp_valid);
    chk("out_rsp_ready", out_rsp_ready, rsp_ready[idx]);
    chk("rsp_tag", rsp_tag, out_rsp_tag[TW+SB-1:SB]);
    chk("rsp_data", rsp_data, out_rsp_data);
    chk("rsp_err", rsp_err, m_err);
    chk("busy", busy, m_out_valid || any_pend);

    if (reset) begin
      if (accept) begin
        m_out_valid  = 1'b1;
        m_out_rw     = req_rw[gidx];
        m_out_addr   = req_addr[gidx*AW +: AW];
        m_out_data   = req_data[gidx*DW +: DW];
        m_out_byteen = req_byteen[gidx*(DW/8) +: DW/8];
        m_out_tag    = {req_tag[gidx*TW +: TW], SB'(gidx)};
        m_ptr        = gidx;
      end else if (out_req_ready) begin
        m_out_valid = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
        bit inc;
        bit dec;
        inc = accept && (gidx == i) && !req_rw[i];
        dec = fire && (idx == i);
        if (inc && !dec) m_pend[i]++;
        else if (dec && !inc) begin
          if (m_pend[i] == 0) m_err = 1'b1;
          else m_pend[i]--;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    req_valid = '0; req_rw = '0; req_addr = '0; req_data = '0;
    req_byteen = '0; req_tag = '0;
    out_req_ready = 1'b1; out_rsp_valid = 1'b0; out_rsp_data = '0;
    out_rsp_tag = '0; rsp_ready = '1;
    model_reset();

    // Reset state
    cycle();
    cycle();
    reset = 1'b1;

    // All four read continuously: strict rotation 0,1,2,3,0,...
    req_valid = 4'hF; req_rw = 4'h0;
    for (int n = 0; n < 8; n++) begin
      #1 chk("rr_order", req_ready, 4'b0001 << (n % 4));
      cycle();
    end
    req_valid = '0;
    do_reset();

    // Credit exhaustion on requester 2 while requester 1 writes
    req_valid = 4'b0110; req_rw = 4'b0010;
    repeat (20) cycle();
    #1 chk("credit_block", req_ready[2], 1'b0);
    out_rsp_valid = 1'b1; out_rsp_tag = {8'h11, 2'd2};
    cycle();
    out_rsp_valid = 1'b0;
    #1 chk("credit_release", req_ready, 4'b0100);
    cycle();
    cycle();
    req_valid = '0;
    do_reset();

    // Output backpressure holds the registered request and the pointer
    req_valid = 4'hF; req_rw = 4'h0;
    cycle();
    cycle();
    out_req_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      #1 chk("stall_ready", req_ready, 4'b0000);
      cycle();
    end
    out_req_ready = 1'b1;
    #1 chk("after_stall_grant", req_ready, 4'b0100);
    cycle();
    req_valid = '0;
    cycle();
    do_reset();

    // Response steering to requester 3 with backpressure
    req_valid = 4'b1000; req_rw = 4'h0;
    cycle();
    req_valid = '0;
    cycle();
    out_rsp_valid = 1'b1; out_rsp_tag = {8'h5A, 2'd3}; rsp_ready = 4'b0111;
    #1 chk("rsp_steer_valid", rsp_valid, 4'b1000);
    chk("rsp_steer_tag", rsp_tag, 8'h5A);
    cycle();
    cycle();
    rsp_ready = 4'hF;
    cycle();
    out_rsp_valid = 1'b0;
    #1 chk("busy_drained", busy, 1'b0);
    cycle();

    // Simultaneous accept and response on requester 1, then a spurious response
    req_valid = 4'b0010; req_rw = 4'h0;
    repeat (3) cycle();
    out_rsp_valid = 1'b1; out_rsp_tag = {8'h33, 2'd1};
    cycle();
    req_valid = '0; out_rsp_valid = 1'b0;
    cycle();
    out_rsp_valid = 1'b1; out_rsp_tag = {8'h44, 2'd0};
    cycle();
    out_rsp_valid = 1'b0;
    #1 chk("spurious_err", rsp_err, 1'b1);
    cycle();

    // Asynchronous reset with reads pending and a request held at the output
    req_valid = 4'b0001; req_rw = 4'b0001;
    cycle();
    req_valid = '0; out_req_ready = 1'b0;
    cycle();
    #2 reset = 1'b0;
    #1 chk("async_out_valid", out_req_valid, 1'b0);
    chk("async_busy", busy, 1'b0);
    chk("async_rsp_err", rsp_err, 1'b0);
    cycle();
    reset = 1'b1; out_req_ready = 1'b1;
    req_valid = 4'hF; req_rw = 4'h0;
    #1 chk("post_reset_grant", req_ready, 4'b0001);
    cycle();
    req_valid = '0; out_rsp_valid = 1'b1; out_rsp_tag = {8'h77, 2'd1};
    cycle();
    out_rsp_valid = 1'b0;
    cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      req_valid     = NR'($urandom);
      req_rw        = NR'($urandom);
      out_req_ready = ($urandom_range(0, 3) != 0);
      out_rsp_valid = ($urandom_range(0, 2) == 0);
      out_rsp_tag   = (TW+SB)'($urandom);
      rsp_ready     = NR'($urandom) | NR'($urandom);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
